// File: rtl/rfft_pkg.sv
// rtl/rfft_pkg.sv - shared types and constants for the RFFT engine sequencer
package rfft_pkg;

    // Sequencer phases: twiddle load once after reset, then load/run/drain per frame.
    typedef enum logic [1:0] {
        TF_LOAD = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int ROWS      = 64;
    localparam int ADDR_W    = 6;
    localparam int TF_ADDR_W = 8;

endpackage

// File: rtl/rfft_skid_fifo.sv
// rtl/rfft_skid_fifo.sv - two-entry skid FIFO absorbing engine read latency under backpressure
//
// Ports:
//   Clk, Reset_n        clock, synchronous active-low reset (FIFO empties)
//   push, push_data     write one entry (ignored when full and not popping)
//   pop                 consume the head entry (ignored when empty)
//   pop_data            head entry, stable until popped
//   empty               no entries held
//   occ                 occupancy 0..2
module rfft_skid_fifo #(
    parameter int DW = 129
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    output logic          empty,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem0_q, mem0_d;
    logic [DW-1:0] mem1_q, mem1_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    occ_q, occ_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        mem0_d   = mem0_q;
        mem1_d   = mem1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;

        do_pop  = pop && (occ_q != 2'd0);
        do_push = push && ((occ_q != 2'd2) || do_pop);

        if (do_push) begin
            if (wr_ptr_q) begin
                mem1_d = push_data;
            end else begin
                mem0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign pop_data = rd_ptr_q ? mem1_q : mem0_q;
    assign empty    = (occ_q == 2'd0);
    assign occ      = occ_q;

endmodule

// File: rtl/rfft_ctrl.sv
// rtl/rfft_ctrl.sv - sequencer for the 256-point banked RFFT engine (twiddle load, frame load/run/drain)
//
// Ports:
//   Clk, Reset_n                    clock, synchronous active-low reset
//   tf_valid/tf_ready/tf_data       twiddle stream, accepted only in TF_LOAD
//   tf_reload                       request twiddle reload (honoured at frame start only)
//   s_valid/s_ready/s_data          4-lane sample stream, one bank row per beat
//   m_valid/m_ready/m_data/m_last   4-lane result stream, m_last on row 63
//   busy, err_timeout, frame_cnt    status: RUN/DRAIN, sticky watchdog, completed frames
//   fft_*                           engine control port (Input/Write/Addr/Din/Tf_in/Tf_we/Addr_T, done, Dout)
module rfft_ctrl
    import rfft_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ROWS     = 64,
    parameter int TF_DEPTH = 256,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 tf_valid,
    output logic                 tf_ready,
    input  logic [2*WIDTH-1:0]   tf_data,
    input  logic                 tf_reload,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [4*WIDTH-1:0]   s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [4*WIDTH-1:0]   m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [15:0]          frame_cnt,
    output logic                 fft_input,
    output logic                 fft_write,
    output logic [ADDR_W-1:0]    fft_addr,
    output logic [WIDTH-1:0]     fft_din0,
    output logic [WIDTH-1:0]     fft_din1,
    output logic [WIDTH-1:0]     fft_din2,
    output logic [WIDTH-1:0]     fft_din3,
    output logic [2*WIDTH-1:0]   fft_tf_in,
    output logic                 fft_tf_we,
    output logic [TF_ADDR_W-1:0] fft_addr_t,
    input  logic                 fft_done,
    input  logic [WIDTH-1:0]     fft_dout0,
    input  logic [WIDTH-1:0]     fft_dout1,
    input  logic [WIDTH-1:0]     fft_dout2,
    input  logic [WIDTH-1:0]     fft_dout3
);

    localparam int WDOG_W = $clog2(TIMEOUT);
    localparam logic [WDOG_W-1:0]    WDOG_MAX = WDOG_W'(TIMEOUT - 1);
    localparam logic [TF_ADDR_W-1:0] TF_LAST  = TF_ADDR_W'(TF_DEPTH - 1);
    localparam logic [ADDR_W-1:0]    ROW_LAST = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W:0]      RD_END   = (ADDR_W + 1)'(ROWS);

    state_t               state_q, state_d;
    logic [TF_ADDR_W-1:0] tf_idx_q, tf_idx_d;
    logic [ADDR_W-1:0]    wr_row_q, wr_row_d;
    logic [ADDR_W:0]      rd_cnt_q, rd_cnt_d;     // extra bit marks "all rows issued"
    logic [WDOG_W-1:0]    wdog_q, wdog_d;
    logic                 inflight_q, inflight_d;
    logic                 infl_last_q, infl_last_d;
    logic                 err_q, err_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 fft_input_q, fft_input_d;

    logic                 tf_acc;
    logic                 s_acc;
    logic                 pop;
    logic                 issue;
    logic [2:0]           pend;
    logic [1:0]           occ;
    logic                 fifo_empty;
    logic [4*WIDTH:0]     fifo_out;

    rfft_skid_fifo #(
        .DW (4*WIDTH + 1)
    ) u_skid (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .push      (inflight_q),
        .push_data ({infl_last_q, fft_dout3, fft_dout2, fft_dout1, fft_dout0}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .occ       (occ)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_out[4*WIDTH-1:0];
    assign m_last  = fifo_out[4*WIDTH];
    assign pop     = m_valid && m_ready;

    assign tf_ready = (state_q == TF_LOAD);
    assign s_ready  = (state_q == LOAD);
    assign tf_acc   = tf_ready && tf_valid;
    assign s_acc    = s_ready && s_valid;

    // Entries that will be held after this cycle plus the one read still in flight
    // must leave a free slot for the read issued now, so a stall never drops data.
    assign pend  = {1'b0, occ} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue = (state_q == DRAIN) && (rd_cnt_q < RD_END) && (pend < 3'd2);

    always_comb begin
        state_d     = state_q;
        tf_idx_d    = tf_idx_q;
        wr_row_d    = wr_row_q;
        rd_cnt_d    = rd_cnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;
        inflight_d  = issue;
        infl_last_d = issue && (rd_cnt_q[ADDR_W-1:0] == ROW_LAST);

        case (state_q)
            TF_LOAD: begin
                if (tf_acc) begin
                    if (tf_idx_q == TF_LAST) begin
                        tf_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        tf_idx_d = tf_idx_q + 1'b1;
                    end
                end
            end
            LOAD: begin
                if (s_acc) begin
                    if (wr_row_q == ROW_LAST) begin
                        wr_row_d = '0;
                        wdog_d   = '0;
                        state_d  = RUN;
                    end else begin
                        wr_row_d = wr_row_q + 1'b1;
                    end
                end else if (tf_reload && (wr_row_q == '0)) begin
                    tf_idx_d = '0;
                    state_d  = TF_LOAD;
                end
            end
            RUN: begin
                if (fft_done) begin
                    rd_cnt_d = '0;
                    state_d  = DRAIN;
                end else if (wdog_q == WDOG_MAX) begin
                    err_d    = 1'b1;
                    wr_row_d = '0;
                    state_d  = LOAD;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DRAIN: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
                if (pop && m_last) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    wr_row_d    = '0;
                    rd_cnt_d    = '0;
                    state_d     = LOAD;
                end
            end
            default: state_d = TF_LOAD;
        endcase

        // Registered so the engine sees Input low exactly for the RUN phase.
        fft_input_d = (state_d != RUN);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= TF_LOAD;
            tf_idx_q    <= '0;
            wr_row_q    <= '0;
            rd_cnt_q    <= '0;
            wdog_q      <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            fft_input_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            tf_idx_q    <= tf_idx_d;
            wr_row_q    <= wr_row_d;
            rd_cnt_q    <= rd_cnt_d;
            wdog_q      <= wdog_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            fft_input_q <= fft_input_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DRAIN);
    assign err_timeout = err_q;
    assign frame_cnt   = frame_cnt_q;
    assign fft_input   = fft_input_q;
    assign fft_write   = s_acc;
    assign fft_addr    = (state_q == DRAIN) ? rd_cnt_q[ADDR_W-1:0] : wr_row_q;
    assign fft_din0    = s_data[0*WIDTH +: WIDTH];
    assign fft_din1    = s_data[1*WIDTH +: WIDTH];
    assign fft_din2    = s_data[2*WIDTH +: WIDTH];
    assign fft_din3    = s_data[3*WIDTH +: WIDTH];
    assign fft_tf_in   = tf_data;
    assign fft_tf_we   = tf_acc;
    assign fft_addr_t  = tf_idx_q;

endmodule
